// File: rtl/shift_right_32_seq.sv
// shift_right_32_seq
// Multi-cycle right shifter, one bit position per enabled clock.
// A start in IDLE loads the operand and shift amount. The block then shifts
// right, filling the MSB with cin (or with the sign bit in arithmetic mode).
// It reports the last bit shifted out of bit 0 on cout, and pulses done for
// one cycle when the shift is complete.
//
// Optional feature macro: SHIFT_RIGHT_ARITH_EN
//   defined   -> arith port exists; latched at start; 1 = sign-fill
//   undefined -> no arith port; fill is always cin
//
// Ports:
//   clk    in  1        rising-edge clock
//   reset  in  1        asynchronous active-high reset
//   en     in  1        global enable; 0 freezes all state
//   start  in  1        request, sampled only in IDLE with en=1
//   a      in  WIDTH    operand, captured at accepted start
//   shamt  in  SHAMT_W  shift amount, captured at accepted start
//   cin    in  1        serial MSB fill in logical mode, sampled live
//   arith  in  1        arithmetic mode select (macro builds only)
//   b      out WIDTH    working / result register
//   cout   out 1        last bit shifted out of bit 0
//   busy   out 1        state != IDLE
//   done   out 1        completion pulse (held while frozen in DONE)

module shift_right_32_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               cin,
`ifdef SHIFT_RIGHT_ARITH_EN
    input  logic               arith,
`endif
    output logic [WIDTH-1:0]   b,
    output logic               cout,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0]   b_n;
    logic               cout_n;
    logic               fill;

`ifdef SHIFT_RIGHT_ARITH_EN
    logic arith_q, arith_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) arith_q <= 1'b0;
        else       arith_q <= arith_n;
    end

    // Sign fill reads the current MSB, so the sign replicates every cycle.
    assign fill = arith_q ? b[WIDTH-1] : cin;
`else
    assign fill = cin;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            b     <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            b     <= b_n;
            cout  <= cout_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        b_n     = b;
        cout_n  = cout;
`ifdef SHIFT_RIGHT_ARITH_EN
        arith_n = arith_q;
`endif
        // With en low nothing moves, including a pending DONE.
        if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_n     = a;
                        cnt_n   = shamt;
                        cout_n  = 1'b0;
`ifdef SHIFT_RIGHT_ARITH_EN
                        arith_n = arith;
`endif
                        state_n = (shamt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    cout_n = b[0];
                    b_n    = {fill, b[WIDTH-1:1]};
                    cnt_n  = cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) state_n = DONE;
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Moore outputs: done stays high if frozen in DONE.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_right_32_seq.sv
module tb_shift_right_32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        cin;
    logic        arith;
    logic [31:0] b;
    logic        cout;
    logic        busy;
    logic        done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    shift_right_32_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .start (start),
        .a     (a),
        .shamt (shamt),
        .cin   (cin),
`ifdef SHIFT_RIGHT_ARITH_EN
        .arith (arith),
`endif
        .b     (b),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    // Call at a negedge; returns at the negedge of cycle 1 after the start edge.
    task automatic issue(input logic [31:0] op, input logic [4:0] sh, input logic ci,
                         input logic ar);
        a     = op;
        shamt = sh;
        cin   = ci;
        arith = ar;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts the cycle number at which done is observed, bounded.
    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; start = 1'b0; a = '0; shamt = '0; cin = 1'b0; arith = 1'b0;
        #2;
        vectors++;
        if (b !== 32'h0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: b=%h cout=%b busy=%b done=%b, want 0/0/0/0", b, cout, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_logical;
        int cyc = 1;
        issue(32'h000F000F, 5'd4, 1'b1, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL logical_busy: busy=%b, want 1", busy);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 5 || b !== 32'hF000F000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL logical: cycle=%0d b=%h cout=%b, want 5 f000f000 1", cyc, b, cout);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || b !== 32'hF000F000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL logical_hold: busy=%b done=%b b=%h cout=%b, want 0 0 f000f000 1", busy, done, b, cout);
        end
    endtask

    task automatic test_shamt_one;
        int cyc = 1;
        issue(32'h80000001, 5'd1, 1'b0, 1'b0);
        wait_done(cyc);
        vectors++;
        if (cyc !== 2 || b !== 32'h40000000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL shamt_one: cycle=%0d b=%h cout=%b, want 2 40000000 1", cyc, b, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_shamt_max;
        int cyc = 1;
        issue(32'h80000000, 5'd31, 1'b1, 1'b0);
        wait_done(cyc);
        vectors++;
        if (cyc !== 32 || b !== 32'hFFFFFFFF || cout !== 1'b0) begin
            errors++;
            $display("FAIL shamt_max: cycle=%0d b=%h cout=%b, want 32 ffffffff 0", cyc, b, cout);
        end
        @(negedge clk);
    endtask

`ifdef SHIFT_RIGHT_ARITH_EN
    task automatic test_arith;
        int cyc = 1;
        issue(32'hF000F37E, 5'd8, 1'b0, 1'b1);
        arith = 1'b0;  // mode must come from the latched value
        wait_done(cyc);
        vectors++;
        if (cyc !== 9 || b !== 32'hFFF000F3 || cout !== 1'b0) begin
            errors++;
            $display("FAIL arith: cycle=%0d b=%h cout=%b, want 9 fff000f3 0", cyc, b, cout);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_zero_shift;
        int cyc = 1;
        int extra = 0;
        issue(32'h00FF0010, 5'd0, 1'b1, 1'b0);
        vectors++;
        if (done !== 1'b1 || b !== 32'h00FF0010 || cout !== 1'b0) begin
            errors++;
            $display("FAIL zero_shift: done=%b b=%h cout=%b, want 1 00ff0010 0", done, b, cout);
        end
        // start during done must be dropped
        a     = 32'h12345678;
        shamt = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        vectors++;
        if (extra !== 0 || b !== 32'h00FF0010) begin
            errors++;
            $display("FAIL zero_no_second: active_cycles=%0d b=%h, want 0 00ff0010", extra, b);
        end
    endtask

    task automatic test_stall;
        int cyc = 1;
        logic [31:0] saved;
        int changed = 0;
        issue(32'h0FF00FF0, 5'd31, 1'b0, 1'b0);
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        en    = 1'b0;
        saved = b;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (b !== saved || done === 1'b1) changed++;
        end
        en = 1'b1;
        vectors++;
        if (changed !== 0) begin
            errors++;
            $display("FAIL stall_freeze: changed_cycles=%0d, want 0", changed);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 35 || b !== 32'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL stall: cycle=%0d b=%h cout=%b, want 35 00000000 0", cyc, b, cout);
        end
        // freeze in DONE: done must stay up until en returns
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_frozen: done=%b, want 1", done);
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_release: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_abort;
        int cyc = 1;
        int dones = 0;
        issue(32'hFFFFFFFF, 5'd20, 1'b1, 1'b0);
        while (cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (b !== 32'h0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: b=%h cout=%b busy=%b done=%b, want 0 0 0 0", b, cout, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d, want 0", dones);
        end
    endtask

    task automatic test_busy_reject;
        int cyc = 1;
        int dones = 0;
        issue(32'h12345678, 5'd10, 1'b0, 1'b0);
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        a     = 32'hFFFFFFFF;
        shamt = 5'd1;
        start = 1'b1;
        @(negedge clk); cyc++;
        start = 1'b0;
        wait_done(cyc);
        vectors++;
        if (cyc !== 11 || b !== 32'h00048D15 || cout !== 1'b1) begin
            errors++;
            $display("FAIL busy_reject: cycle=%0d b=%h cout=%b, want 11 00048d15 1", cyc, b, cout);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL busy_single_done: extra_dones=%0d, want 0", dones);
        end
    endtask

    task automatic test_back_to_back;
        int cyc = 1;
        issue(32'h00000003, 5'd1, 1'b0, 1'b0);
        wait_done(cyc);
        @(negedge clk);  // IDLE re-accept cycle
        cyc = 1;
        issue(32'hA5A5A5A5, 5'd2, 1'b0, 1'b0);
        wait_done(cyc);
        vectors++;
        if (cyc !== 3 || b !== 32'h29696969 || cout !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: cycle=%0d b=%h cout=%b, want 3 29696969 0", cyc, b, cout);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_logical();
        test_shamt_one();
        test_shamt_max();
`ifdef SHIFT_RIGHT_ARITH_EN
        test_arith();
`endif
        test_zero_shift();
        test_stall();
        test_abort();
        test_busy_reject();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_32_seq.md
# shift_right_32_seq

Sequential 32-bit right shifter. It is the companion to the combinational left-shift datapath and carries the same `a`/`b`/`cin`/`cout`/`en` signal set.
- A `start` request loads an operand and a shift amount.
- The block shifts one bit position per enabled clock, filling the MSB with `cin`, or with the sign bit in arithmetic mode.
- It reports the last bit shifted out on `cout`, then signals completion with a one-cycle `done` pulse.
- It sits beside the ALU shift path as the multi-cycle right-shift resource.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.
- `SHAMT_W`, 5, shift-amount width; maximum shift is 2^SHAMT_W - 1 = 31.

Ports:
- `clk`  in  1  Single clock for all state; rising-edge triggered.
- `reset`  in  1  Asynchronous reset, active-high. Forces IDLE and clears all outputs.
- `en`  in  1  Global enable. When 0, the FSM and all registers hold; `start` is ignored.
- `start`  in  1  Request pulse. Sampled only in IDLE with `en`=1.
- `a`  in  WIDTH  Operand, captured on the accepted `start` edge.
- `shamt`  in  SHAMT_W  Shift amount, captured on the accepted `start` edge.
- `cin`  in  1  Serial fill bit for the MSB in logical mode. Sampled live on every shift cycle.
- `arith`  in  1  1 = arithmetic shift (MSB fill = current bit WIDTH-1). Present only with `SHIFT_RIGHT_ARITH_EN`.
- `b`  out  WIDTH  Working/result register.
- `cout`  out  1  Last bit shifted out of bit 0.
- `busy`  out  1  High whenever state ≠ IDLE.
- `done`  out  1  One-cycle completion pulse.

## Operation
States and transitions (all transitions require `en`=1):
- IDLE: on `start`=1:
  - load `b`←`a` and `cnt`←`shamt`; clear `cout`←0; latch the mode.
  - go to SHIFT if `shamt`≠0, otherwise go to DONE.
- SHIFT: each cycle:
  - `cout`←`b[0]`.
  - `b`←{fill, `b[WIDTH-1:1]`}, where fill = `b[WIDTH-1]` if the latched `arith`=1, else `cin`.
  - `cnt`←`cnt`-1.
  - When `cnt`==1, go to DONE.
- DONE: `done`=1 for exactly this cycle; next state is IDLE.

Output rules:
- `b` and `cout` are valid while `done`=1, and hold their value in IDLE until the next accepted `start`.
- `start` asserted while `busy`=1 is ignored; it is not queued.
- `start` asserted in the same cycle as `done` is ignored. It is accepted from IDLE on the following cycle.
- `en`=0 in any state freezes `state`, `cnt`, `b` and `cout`. `done` stays high if the block is frozen in DONE and is released when `en` returns.
- The result equals `a` >> `shamt`, with the vacated MSBs filled as specified above. For `shamt`=0: `b`=`a` and `cout`=0.

## Timing
- Reset values: state=IDLE, `b`=0, `cout`=0, `busy`=0, `done`=0, `cnt`=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-SHIFT aborts the operation. No `done` pulse is generated.
- Latency with `en` held high: `done` is high in clock cycle `shamt`+1 after the accepted `start` edge.
  - `shamt`=0 gives 1 cycle.
  - `shamt`=31 gives 32 cycles.
- Each cycle with `en`=0 adds one cycle of latency.
- `busy` rises in the cycle after the accepted `start` edge. It falls in the cycle after `done`.
- Throughput: one operation per `shamt`+2 cycles at most, including the IDLE re-accept cycle.

## Configuration
- Macro: `SHIFT_RIGHT_ARITH_EN`.
- Defined: the `arith` port exists and is latched at `start`. `arith`=1 replicates the sign bit on every shift cycle, and `cin` is ignored.
- Undefined: there is no `arith` port; the fill bit is always `cin` (logical/serial-in shift only).
- All other behaviour and timing are identical in both builds.

## Test plan
- Logical shift: `a`=0x000F000F, `shamt`=4, `cin`=1, `en`=1 → `done` in cycle 5, `b`=0xF000F000, `cout`=1.
- Arithmetic shift (macro defined): `a`=0xF000F37E, `shamt`=8, `arith`=1 → `done` in cycle 9, `b`=0xFFF000F3, `cout`=0.
- Zero shift: `a`=0x00FF0010, `shamt`=0 → `done` in cycle 1, `b`=0x00FF0010, `cout`=0. A `start` pulse asserted during `done` produces no second `done`.
- Stall: `a`=0x0FF00FF0, `shamt`=31, `cin`=0, with `en`=0 for 3 cycles mid-SHIFT → `done` in cycle 35, `b`=0x00000000, `cout`=0. `b` is unchanged during the stall cycles.
- Reset/abort: `start` with `a`=0xFFFFFFFF, `shamt`=20; assert `reset` at cycle 6 → `b`=0, `cout`=0, `busy`=0 immediately, and no `done` follows.
- Busy rejection: a second `start` with different `a` at cycle 3 of a `shamt`=10 operation → the result matches the first operand only, and `done` occurs once, in cycle 11.
